// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADC  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_SUC  = 8'h04;
  localparam logic [7:0] OP_CMP  = 8'h05;
  localparam logic [7:0] OP_MUL8 = 8'h06;
  localparam logic [7:0] OP_DIV8 = 8'h07;
  localparam logic [7:0] OP_MUL6 = 8'h08;
  localparam logic [7:0] OP_DIV6 = 8'h09;
  localparam logic [7:0] OP_TEST = 8'h0A;
  localparam logic [7:0] OP_AND  = 8'h0B;
  localparam logic [7:0] OP_NEG  = 8'h0C;
  localparam logic [7:0] OP_NOT  = 8'h0D;
  localparam logic [7:0] OP_OR   = 8'h0E;
  localparam logic [7:0] OP_SHL  = 8'h0F;
  localparam logic [7:0] OP_SHR  = 8'h10;
  localparam logic [7:0] OP_XOR  = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_O = 2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, flag-update class and writeback ports.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [7:0] op,
  output logic       legal,
  output logic       upd_czo,
  output logic       upd_z,
  output logic       wr_lo,
  output logic       wr_hi,
  output logic       is_div8,
  output logic       is_div16
);

  // Map each opcode onto its flag/writeback class; anything unlisted is illegal.
  always_comb begin
    legal    = 1'b1;
    upd_czo  = 1'b0;
    upd_z    = 1'b0;
    wr_lo    = 1'b0;
    wr_hi    = 1'b0;
    is_div8  = 1'b0;
    is_div16 = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SUC: begin
        upd_czo = 1'b1;
        wr_lo   = 1'b1;
      end
      OP_CMP: upd_czo = 1'b1;
      OP_MUL8: begin
        upd_z = 1'b1;
        wr_lo = 1'b1;
      end
      OP_DIV8: begin
        upd_z   = 1'b1;
        wr_lo   = 1'b1;
        is_div8 = 1'b1;
      end
      OP_MUL6: begin
        upd_z = 1'b1;
        wr_lo = 1'b1;
        wr_hi = 1'b1;
      end
      OP_DIV6: begin
        upd_z    = 1'b1;
        wr_lo    = 1'b1;
        wr_hi    = 1'b1;
        is_div16 = 1'b1;
      end
      OP_TEST: upd_z = 1'b1;
      OP_AND, OP_NEG, OP_NOT, OP_OR, OP_SHL, OP_SHR, OP_XOR: wr_lo = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Issue-side controller for the 16-bit ALU: accepts one op, issues it, captures the
// registered result, applies per-class writeback/flag rules and holds the flags.
//
//   state | meaning
//   IDLE  | ready for a request; rejects illegal ops / zero divisors with err
//   EXEC  | ALU samples the issued op on this edge; op bus returns to NOP
//   CAPT  | ALU result is valid; register writeback and flag updates
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DST_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [DST_W-1:0] req_dst,
  output logic [7:0]       alu_op,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic             alu_cf,
  input  logic [15:0]      alu_acc,
  input  logic [15:0]      alu_c,
  input  logic             alu_c_flag,
  input  logic             alu_z_flag,
  input  logic             alu_o_flag,
  output logic             wb_valid,
  output logic [DST_W-1:0] wb_dst,
  output logic [15:0]      wb_data,
  output logic             wb_hi_valid,
  output logic [15:0]      wb_hi_data,
  output logic [2:0]       flags,
  output logic             err
);

  state_e             state_q, state_d;
  logic [7:0]         alu_op_q, alu_op_d;
  logic [15:0]        alu_a_q, alu_a_d;
  logic [15:0]        alu_b_q, alu_b_d;
  logic               alu_cf_q, alu_cf_d;
  logic [DST_W-1:0]   dst_q, dst_d;
  logic               upd_czo_q, upd_czo_d;
  logic               upd_z_q, upd_z_d;
  logic               wr_lo_q, wr_lo_d;
  logic               wr_hi_q, wr_hi_d;
  logic               wb_valid_q, wb_valid_d;
  logic [DST_W-1:0]   wb_dst_q, wb_dst_d;
  logic [15:0]        wb_data_q, wb_data_d;
  logic               wb_hi_valid_q, wb_hi_valid_d;
  logic [15:0]        wb_hi_data_q, wb_hi_data_d;
  logic [2:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic dec_legal, dec_upd_czo, dec_upd_z, dec_wr_lo, dec_wr_hi;
  logic dec_is_div8, dec_is_div16;
  logic accept, bad_div;

  alu_op_decode u_dec (
    .op       (req_op),
    .legal    (dec_legal),
    .upd_czo  (dec_upd_czo),
    .upd_z    (dec_upd_z),
    .wr_lo    (dec_wr_lo),
    .wr_hi    (dec_wr_hi),
    .is_div8  (dec_is_div8),
    .is_div16 (dec_is_div16)
  );

  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  // Divide-by-zero is rejected up front so the ALU never sees it.
  assign bad_div   = (dec_is_div8 & (req_b[7:0] == 8'h00)) |
                     (dec_is_div16 & (req_b == 16'h0000));

  // Next-state and registered-output logic for the three-phase issue sequence.
  always_comb begin
    state_d       = state_q;
    alu_op_d      = OP_NOP;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cf_d      = alu_cf_q;
    dst_d         = dst_q;
    upd_czo_d     = upd_czo_q;
    upd_z_d       = upd_z_q;
    wr_lo_d       = wr_lo_q;
    wr_hi_d       = wr_hi_q;
    wb_valid_d    = 1'b0;
    wb_dst_d      = wb_dst_q;
    wb_data_d     = wb_data_q;
    wb_hi_valid_d = 1'b0;
    wb_hi_data_d  = wb_hi_data_q;
    flags_d       = flags_q;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!dec_legal || bad_div) begin
            err_d = 1'b1;
          end else begin
            alu_op_d  = req_op;
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_cf_d  = flags_q[FLG_C];
            dst_d     = req_dst;
            upd_czo_d = dec_upd_czo;
            upd_z_d   = dec_upd_z;
            wr_lo_d   = dec_wr_lo;
            wr_hi_d   = dec_wr_hi;
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: begin
        state_d = ST_IDLE;
        if (wr_lo_q) begin
          wb_valid_d = 1'b1;
          wb_dst_d   = dst_q;
          wb_data_d  = alu_acc;
        end
        if (wr_hi_q) begin
          wb_hi_valid_d = 1'b1;
          wb_hi_data_d  = alu_c;
        end
        // The ALU leaves stale flags for logic ops; only the op's class may touch them.
        if (upd_czo_q) begin
          flags_d[FLG_C] = alu_c_flag;
          flags_d[FLG_Z] = alu_z_flag;
          flags_d[FLG_O] = alu_o_flag;
        end else if (upd_z_q) begin
          flags_d[FLG_Z] = alu_z_flag;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight op without writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      alu_op_q      <= OP_NOP;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cf_q      <= 1'b0;
      dst_q         <= '0;
      upd_czo_q     <= 1'b0;
      upd_z_q       <= 1'b0;
      wr_lo_q       <= 1'b0;
      wr_hi_q       <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_dst_q      <= '0;
      wb_data_q     <= '0;
      wb_hi_valid_q <= 1'b0;
      wb_hi_data_q  <= '0;
      flags_q       <= 3'b000;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cf_q      <= alu_cf_d;
      dst_q         <= dst_d;
      upd_czo_q     <= upd_czo_d;
      upd_z_q       <= upd_z_d;
      wr_lo_q       <= wr_lo_d;
      wr_hi_q       <= wr_hi_d;
      wb_valid_q    <= wb_valid_d;
      wb_dst_q      <= wb_dst_d;
      wb_data_q     <= wb_data_d;
      wb_hi_valid_q <= wb_hi_valid_d;
      wb_hi_data_q  <= wb_hi_data_d;
      flags_q       <= flags_d;
      err_q         <= err_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cf      = alu_cf_q;
  assign wb_valid    = wb_valid_q;
  assign wb_dst      = wb_dst_q;
  assign wb_data     = wb_data_q;
  assign wb_hi_valid = wb_hi_valid_q;
  assign wb_hi_data  = wb_hi_data_q;
  assign flags       = flags_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: stand-in registered ALU, behavioural reference model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_alu_ctrl;

  localparam logic [7:0] ADD = 8'h01, ADC = 8'h02, SUB = 8'h03, SUC = 8'h04, CMP = 8'h05;
  localparam logic [7:0] MUL8 = 8'h06, DIV8 = 8'h07, MUL6 = 8'h08, DIV6 = 8'h09, TEST = 8'h0A;
  localparam logic [7:0] AND_ = 8'h0B, NEG = 8'h0C, NOT_ = 8'h0D, OR_ = 8'h0E;
  localparam logic [7:0] SHL = 8'h0F, SHR = 8'h10, XOR_ = 8'h11;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c;
    logic        z;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [2:0]  req_dst;
  logic [7:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_cf;
  logic [15:0] alu_acc = '0, alu_c = '0;
  logic        alu_c_flag = 1'b0, alu_z_flag = 1'b0, alu_o_flag = 1'b0;
  logic        wb_valid, wb_hi_valid, err;
  logic [2:0]  wb_dst, flags;
  logic [15:0] wb_data, wb_hi_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.DST_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cf(alu_cf),
    .alu_acc(alu_acc), .alu_c(alu_c),
    .alu_c_flag(alu_c_flag), .alu_z_flag(alu_z_flag), .alu_o_flag(alu_o_flag),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_hi_valid(wb_hi_valid), .wb_hi_data(wb_hi_data),
    .flags(flags), .err(err)
  );

  // Arithmetic meaning of every opcode.
  function automatic res_t ref_result(input logic [7:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic cin);
    res_t r;
    logic [16:0] s;
    logic [31:0] p;
    r = '0;
    s = '0;
    p = '0;
    case (op)
      ADD, ADC: begin
        s = {1'b0, a} + {1'b0, b} + ((op == ADC) ? 17'(cin) : 17'd0);
        r.lo = s[15:0];
        r.c = s[16];
        r.o = (a[15] == b[15]) && (r.lo[15] != a[15]);
      end
      SUB, SUC, CMP: begin
        s = {1'b0, a} - {1'b0, b} - ((op == SUC) ? 17'(cin) : 17'd0);
        r.lo = s[15:0];
        r.c = s[16];
        r.o = (a[15] != b[15]) && (r.lo[15] != a[15]);
      end
      MUL8: r.lo = a[7:0] * b[7:0];
      DIV8: r.lo = a / {8'h00, b[7:0]};
      MUL6: begin
        p = a * b;
        r.lo = p[15:0];
        r.hi = p[31:16];
      end
      DIV6: begin
        r.lo = a / b;
        r.hi = a % b;
      end
      TEST, AND_: r.lo = a & b;
      NEG: r.lo = -a;
      NOT_: r.lo = ~a;
      OR_: r.lo = a | b;
      SHL: r.lo = a << b[3:0];
      SHR: r.lo = a >> b[3:0];
      XOR_: r.lo = a ^ b;
      default: r.lo = '0;
    endcase
    r.z = (r.lo == 16'h0000);
    return r;
  endfunction

  // Stand-in ALU: registered result, holds on NOP, junk flags where they carry no meaning.
  always @(posedge clk) begin : alu_standin
    res_t r;
    if (alu_op != 8'h00) begin
      r = ref_result(alu_op, alu_a, alu_b, alu_cf);
      alu_acc <= r.lo;
      if (alu_op inside {MUL6, DIV6}) alu_c <= r.hi;
      if (alu_op inside {ADD, ADC, SUB, SUC, CMP}) begin
        alu_c_flag <= r.c;
        alu_o_flag <= r.o;
      end else begin
        alu_c_flag <= 1'($urandom_range(0, 1));
        alu_o_flag <= 1'($urandom_range(0, 1));
      end
      if (alu_op inside {AND_, NEG, NOT_, OR_, SHL, SHR, XOR_})
        alu_z_flag <= 1'($urandom_range(0, 1));
      else
        alu_z_flag <= r.z;
    end
  end

  // Reference model: cycles since acceptance, architectural flags, expected outputs.
  int          m_age;
  logic [2:0]  m_flags;
  res_t        m_res;
  logic [7:0]  m_op;
  logic [2:0]  m_dst;
  logic        exp_issue, exp_wb_valid, exp_hi_valid, exp_err;
  logic [7:0]  exp_alu_op;
  logic [15:0] exp_alu_a, exp_alu_b, exp_wb_data, exp_hi_data;
  logic        exp_alu_cf;
  logic [2:0]  exp_wb_dst;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_flags = 3'b000; m_op = 8'h00; m_dst = '0; m_res = '0;
      exp_issue = 0; exp_wb_valid = 0; exp_hi_valid = 0; exp_err = 0;
      exp_alu_op = 8'h00; exp_alu_a = '0; exp_alu_b = '0; exp_alu_cf = 0;
      exp_wb_dst = '0; exp_wb_data = '0; exp_hi_data = '0;
    end else begin
      exp_issue = 0; exp_wb_valid = 0; exp_hi_valid = 0; exp_err = 0; exp_alu_op = 8'h00;
      if (m_age == 2) begin
        m_age = 0;
        if (!(m_op inside {CMP, TEST})) begin
          exp_wb_valid = 1; exp_wb_dst = m_dst; exp_wb_data = m_res.lo;
        end
        if (m_op inside {MUL6, DIV6}) begin
          exp_hi_valid = 1; exp_hi_data = m_res.hi;
        end
        if (m_op inside {ADD, ADC, SUB, SUC, CMP}) m_flags = {m_res.o, m_res.z, m_res.c};
        else if (m_op inside {MUL8, DIV8, MUL6, DIV6, TEST}) m_flags[1] = m_res.z;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (req_valid) begin
        if (req_op < 8'h01 || req_op > 8'h11 || (req_op == DIV8 && req_b[7:0] == 8'h00) ||
            (req_op == DIV6 && req_b == 16'h0000)) begin
          exp_err = 1;
        end else begin
          m_op = req_op; m_dst = req_dst;
          m_res = ref_result(req_op, req_a, req_b, m_flags[0]);
          exp_issue = 1; exp_alu_op = req_op; exp_alu_a = req_a; exp_alu_b = req_b;
          exp_alu_cf = m_flags[0];
          m_age = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs", {req_ready, alu_op, alu_cf, wb_valid, wb_hi_valid, err, flags, wb_dst},
            32'h0);
      check("rst_data", {alu_a, alu_b}, 32'h0);
      check("rst_wb_data", {wb_data, wb_hi_data}, 32'h0);
    end else begin
      check("req_ready", req_ready, (m_age == 0));
      check("alu_op", alu_op, exp_alu_op);
      check("wb_valid", wb_valid, exp_wb_valid);
      check("wb_hi_valid", wb_hi_valid, exp_hi_valid);
      check("err", err, exp_err);
      check("flags", flags, m_flags);
      if (exp_issue) begin
        check("alu_a", alu_a, exp_alu_a);
        check("alu_b", alu_b, exp_alu_b);
        check("alu_cf", alu_cf, exp_alu_cf);
      end
      if (exp_wb_valid) begin
        check("wb_dst", wb_dst, exp_wb_dst);
        check("wb_data", wb_data, exp_wb_data);
      end
      if (exp_hi_valid) check("wb_hi_data", wb_hi_data, exp_hi_data);
    end
  end

  // Present a request for one edge; returns at the falling edge of the EXEC cycle.
  task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dst);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_dst = dst;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    @(negedge clk);
  endtask

  // From the EXEC falling edge to the falling edge of the writeback cycle.
  task automatic wait_wb();
    @(posedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic reject(input string name, input logic [7:0] op, input logic [15:0] b);
    issue(op, 16'h0055, b, 3'd7);
    check({name, "_err"}, err, 1'b1);
    check({name, "_alu_op"}, alu_op, 8'h00);
    @(negedge clk);
    check({name, "_err_pulse"}, err, 1'b0);
    check({name, "_no_wb"}, wb_valid, 1'b0);
  endtask

  typedef struct {logic [7:0] op; logic [15:0] a; logic [15:0] b;} vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_dst = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("lit_reset_ready", req_ready, 1'b1);
    check("lit_reset_flags", flags, 3'b000);
    check("lit_reset_wb", {wb_valid, wb_data}, 17'h0);

    issue(ADD, 16'h7FFF, 16'h0001, 3'd2); wait_wb();
    check("lit_add_wb_valid", wb_valid, 1'b1);
    check("lit_add_wb_dst", wb_dst, 3'd2);
    check("lit_add_wb_data", wb_data, 16'h8000);
    check("lit_add_flags", flags, 3'b100);

    issue(ADD, 16'hFFFF, 16'hFFFF, 3'd1); wait_wb();
    check("lit_add2_data", wb_data, 16'hFFFE);
    check("lit_add2_flags", flags, 3'b001);
    issue(ADC, 16'h0001, 16'h0001, 3'd4);
    check("lit_adc_cf", alu_cf, 1'b1);
    wait_wb();
    check("lit_adc_data", wb_data, 16'h0003);

    issue(ADD, 16'h8000, 16'h8000, 3'd5); wait_wb();
    check("lit_add3_flags", flags, 3'b111);
    issue(MUL6, 16'h1234, 16'h0100, 3'd3); wait_wb();
    check("lit_mul6_lo", wb_data, 16'h3400);
    check("lit_mul6_hi_valid", wb_hi_valid, 1'b1);
    check("lit_mul6_hi", wb_hi_data, 16'h0012);
    check("lit_mul6_flags", flags, 3'b101);

    reject("div6_zero", DIV6, 16'h0000);
    reject("op_12", 8'h12, 16'h0003);
    reject("op_00", 8'h00, 16'h0003);
    reject("div8_zero", DIV8, 16'h0100);
    check("lit_reject_flags", flags, 3'b101);

    issue(CMP, 16'd5, 16'd9, 3'd1); wait_wb();
    check("lit_cmp_no_wb", wb_valid, 1'b0);
    check("lit_cmp_flags", flags, 3'b001);
    issue(AND_, 16'hF0F0, 16'h0FF0, 3'd6); wait_wb();
    check("lit_and_data", wb_data, 16'h00F0);
    check("lit_and_flags", flags, 3'b001);

    tbl[0] = '{SUB, 16'd3, 16'd5};        tbl[1] = '{SUC, 16'h8000, 16'h0001};
    tbl[2] = '{TEST, 16'h00FF, 16'hFF00}; tbl[3] = '{OR_, 16'h1200, 16'h0034};
    tbl[4] = '{XOR_, 16'hAAAA, 16'hAAAA}; tbl[5] = '{NOT_, 16'h0F0F, 16'h0000};
    tbl[6] = '{NEG, 16'h0001, 16'h0000};  tbl[7] = '{SHL, 16'h0003, 16'h0004};
    tbl[8] = '{SHR, 16'h8000, 16'h000F};  tbl[9] = '{MUL8, 16'hFF10, 16'h0010};
    tbl[10] = '{DIV8, 16'd200, 16'hAB07}; tbl[11] = '{DIV6, 16'd100, 16'd7};
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 3'(i));
      wait_wb();
    end

    // Requests held continuously: one accepted every third edge, others ignored.
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_op = (i % 2 == 0) ? SUC : ADC;
      req_a = 16'(i * 16'h1111); req_b = 16'hF000; req_dst = 3'(i);
      repeat (3) begin @(posedge clk); #1; end
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);

    issue(ADD, 16'h0010, 16'h0020, 3'd3);
    #1 rst = 1'b1;
    @(negedge clk);
    check("lit_rst_exec_ready", req_ready, 1'b0);
    check("lit_rst_exec_out", {wb_valid, alu_op, flags}, 12'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("lit_rst_release_ready", req_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("lit_rst_no_wb", wb_valid, 1'b0);

    issue(ADD, 16'd2, 16'd3, 3'd1); wait_wb();
    check("lit_post_rst_data", wb_data, 16'h0005);
    check("lit_post_rst_flags", flags, 3'b000);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Issue-side controller for the 16-bit `alu`. It accepts one operation at a time over a valid/ready request port and drives `op`/`a`/`b`/`cf` into the ALU. After the ALU's registered result appears, it captures `acc`/`c`/flags, applies per-opcode flag-update and writeback rules, and holds the architectural flag register. It sits between instruction decode and the register-file write port.

## Interface
Parameters:
- `DST_W`, default 3: width of the destination register index.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: `(state==IDLE) & ~rst`.
- `req_op` in 8: ALU opcode, 0x01..0x11.
- `req_a`, `req_b` in 16: operands.
- `req_dst` in DST_W: destination register index.
- `alu_op` out 8: to ALU `op`; 0x00 (NOP; ALU holds its state) whenever not issuing.
- `alu_a`, `alu_b` out 16: to ALU `a`/`b`.
- `alu_cf` out 1: to ALU `cf`.
- `alu_acc`, `alu_c` in 16: from ALU.
- `alu_c_flag`, `alu_z_flag`, `alu_o_flag` in 1: from ALU.
- `wb_valid` out 1: one-cycle writeback strobe.
- `wb_dst` out DST_W: writeback register index.
- `wb_data` out 16: low result (`acc`).
- `wb_hi_valid` out 1: high result present (MUL6/DIV6 only).
- `wb_hi_data` out 16: high result (`c`).
- `flags` out 3: `{o,z,c}` architectural flags.
- `err` out 1: one-cycle pulse on rejected request.

## Operation
- FSM states: IDLE, EXEC, CAPT.
- **IDLE:** on `req_valid & req_ready`, latch `op`, `a`, `b`, `dst`. Latch `cf = flags[0]`.
  - Illegal op (0x00 or >0x11) -> `err`=1 next cycle, stay IDLE.
  - DIV8 with `b[7:0]==0`, or DIV6 with `b==0` -> same handling as illegal op.
  - Rejected requests cause no ALU issue, no writeback, and no flag change.
  - Otherwise register `alu_op/a/b/cf` and go to EXEC.
- **EXEC:** ALU samples on this edge. Drive `alu_op`=0x00 and go to CAPT.
- **CAPT:** register the ALU outputs per the decode class below, then go to IDLE.
- Decode classes:
  - ADD/ADC/SUB/SUC: write `acc`; update c, z, o.
  - CMP: no write; update c, z, o.
  - MUL8/DIV8: write `acc`; update z only.
  - MUL6/DIV6: write `acc` and `c` (`wb_hi_valid`); update z only.
  - TEST: no write; update z only.
  - AND/NEG/NOT/OR/SHL/SHR/XOR: write `acc`; flags unchanged. The ALU leaves stale flags for these ops; the controller must mask them.
- Flags not updated by an op keep their prior value.

## Timing
- Accept at edge N; ALU computes at N+1; `wb_*` and `flags` are valid in the cycle after edge N+2.
- Next accept is possible at edge N+3, giving throughput of one op per 3 cycles.
- `wb_valid`, `wb_hi_valid`, and `err` are single-cycle pulses.
- `wb_dst`/`wb_data`/`wb_hi_data` hold their value until the next writeback.
- `alu_cf` is sampled from `flags` at accept. Flags written at N+2 are therefore visible to a request accepted at N+3 (ADC/SUC chains are correct).
- `req_*` is ignored outside IDLE. Inputs may change freely after acceptance.
- Reset values: state IDLE, `alu_op`/`alu_a`/`alu_b`/`alu_cf`=0, `wb_*`=0, `flags`=3'b000, `err`=0.
- Reset asserted in EXEC or CAPT: abort with no writeback and no flag update. The ALU itself has no reset; its stale outputs are ignored.

## Structure
- Package `alu_pkg`: opcode constants 0x01..0x11, state enum, `flags` bit indices (C=0, Z=1, O=2).
- Sub-module `alu_op_decode` (combinational), outputs:
  - `legal`
  - `upd_czo`
  - `upd_z`
  - `wr_lo`
  - `wr_hi`
  - `is_div8`
  - `is_div16`
- `alu_ctrl` holds the FSM, operand/result registers, and flag register.

## Test plan
- ADD 0x7FFF+0x0001, dst=2 -> `wb_valid` 2 edges after accept; `wb_dst`=2, `wb_data`=0x8000, `flags`={o=1,z=0,c=0}.
- ADD 0xFFFF+0xFFFF, then ADC 0x0001+0x0001 -> first op gives `wb_data`=0xFFFE, c=1, o=0; ADC gets `alu_cf`=1 and gives `wb_data`=0x0003.
- MUL6 0x1234*0x0100 -> `wb_data`=0x3400, `wb_hi_valid`=1, `wb_hi_data`=0x0012; z=0; c and o unchanged.
- DIV6 with b=0, and op 0x12 -> `err` pulse each; `alu_op` stays 0x00; no `wb_valid`; `flags` unchanged.
- CMP 5 vs 9, then AND 0xF0F0&0x0FF0 -> CMP gives no writeback and `flags`={0,0,1}; AND gives `wb_data`=0x00F0 and `flags` still {0,0,1}.
- Assert `rst` during EXEC -> no `wb_valid`; all outputs 0; `req_ready`=0 while reset is held and 1 on the first cycle after release.
